uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
// - On-chip end of the UART program-load link: receives 8N1 serial bytes on the
//   user-project RX pin (mprj_io[5]), packs them little-endian into 32-bit words
//   and writes them sequentially into core instruction memory.
// - Holds the core in reset until an END_WORD marker arrives, then releases it.
// - Drives rdy_o (routed to mprj_io[37]) to signal the host it may start sending.
// PARAMETERS
// - CLKS_PER_BIT  87            clk cycles per UART bit (10 MHz / 115200); must be >= 4
// - ADDR_W        14            word-address width of mem_addr_o
// - BASE_ADDR     0             first word address written
// - END_WORD      32'h0000_0FFF assembled word that terminates loading (never written)
// PORTS
// - clk          in   1       core clock
// - rst_l        in   1       asynchronous active-low reset
// - en_i         in   1       loader enable; low = hold in IDLE, no sampling
// - rx_i         in   1       UART serial input, idle high, asynchronous to clk
// - mem_we_o     out  1       write request; held until accepted
// - mem_addr_o   out  ADDR_W  word address of current write
// - mem_wdata_o  out  32      write data
// - mem_ready_i  in   1       memory accepts write when mem_we_o & mem_ready_i
// - rdy_o        out  1       loader armed and accepting bytes
// - done_o       out  1       END_WORD received; sticky until reset
// - core_rst_l_o out  1       core reset; low until done_o
// - frame_err_o  out  1       sticky: stop bit sampled low
// - overrun_o    out  1       sticky: word completed while previous write pending
// BEHAVIOUR
// - Reset: all outputs 0 except core_rst_l_o=0; mem_addr_o=BASE_ADDR; FSM=IDLE.
// - rx_i passes a 2-flop synchronizer (reset value 1); all sampling uses synced value.
// - rdy_o = en_i & ~done_o, registered (1-cycle lag from en_i).
// - RX FSM: IDLE -> START on synced rx==0 (only when rdy_o).
//   START: wait CLKS_PER_BIT/2 (integer division); rx==0 -> DATA, else -> IDLE (glitch).
//   DATA: 8 samples spaced CLKS_PER_BIT, LSB first -> STOP.
//   STOP: sample after CLKS_PER_BIT; 1 = byte valid; 0 = set frame_err_o, drop byte,
//   and clear the partial word (byte index -> 0). Either case -> IDLE next cycle.
// - Packer: byte index 0..3; byte k -> wdata[8k+7:8k]; index wraps 3->0 on word completion.
// - Word complete, word == END_WORD: no write; done_o=1, core_rst_l_o=1 next cycle;
//   FSM stays IDLE thereafter.
// - Otherwise, word complete with no pending write: mem_we_o=1 next cycle with
//   addr/data stable.
// - Handshake: on mem_we_o & mem_ready_i, mem_we_o drops next cycle and mem_addr_o
//   increments by 1, wrapping modulo 2^ADDR_W.
// - Word completes while mem_we_o still high: set overrun_o, discard the new word,
//   keep the pending write unchanged.
// - en_i deasserted mid-frame: FSM -> IDLE next cycle; partial word and byte index
//   cleared; a pending write completes normally; address is not reset.
// - rst_l asserted mid-operation: immediate return to reset state, including address.
// - Word write latency: stop-bit sample of the 4th byte to mem_we_o = 1 clk.
// TESTING
// - Reset: rst_l=0 with rx_i toggling -> all outputs reset values, no mem_we_o.
//   Release rst_l with en_i=1 -> rdy_o=1 after 1 clk.
// - Bytes 13 00 00 00 then 93 00 10 00 -> writes (addr 0, 0x00000013), then
//   (addr 1, 0x00100093).
// - Bytes FF 0F 00 00 -> no write; done_o=1 and core_rst_l_o=1 one clk after the stop
//   sample. Further bytes are ignored.
// - Send byte 0x55 with stop bit low -> frame_err_o=1, byte index reset.
//   Next 4 good bytes AA BB CC DD -> write 0xDDCCBBAA.
// - Hold mem_ready_i=0 across two full words 0x11111111, 0x22222222 -> overrun_o=1;
//   only 0x11111111 is written once mem_ready_i=1; address advances by 1.
// - 1/4-bit low glitch on rx_i -> START aborts to IDLE, no byte counted.
//   Drop en_i after 2 bytes -> partial word discarded.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives 8N1 UART bytes, packs them little-endian into words,
// writes them to instruction memory and releases the core on an END_WORD marker.
module uart_prog_loader #(
  parameter int              CLKS_PER_BIT = 87,
  parameter int              ADDR_W       = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]     END_WORD     = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en_i,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              rdy_o,
  output logic              done_o,
  output logic              core_rst_l_o,
  output logic              frame_err_o,
  output logic              overrun_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic              rx_s1_q, rx_s2_q, rdy_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d, done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, full;
  logic              byte_ok;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    byte_ok = 1'b0;
    full    = {shift_q, word_q};
    if (we_q && mem_ready_i) begin
      we_d   = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    if (!en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (rdy_q && !done_q && !rx_s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
        START: if (cnt_q == HALF_M1) begin
          state_d = rx_s2_q ? IDLE : DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        DATA: if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
        end else cnt_d = cnt_q + 1'b1;
        default: if (cnt_q == FULL_M1) begin
          state_d = IDLE;
          byte_ok = rx_s2_q;
          ferr_d  = ferr_q | ~rx_s2_q;
          idx_d   = rx_s2_q ? idx_q : 2'd0;
          word_d  = rx_s2_q ? word_q : 24'd0;
        end else cnt_d = cnt_q + 1'b1;
      endcase
    end
    // A completed word is either the end marker, an overrun, or a new write.
    if (byte_ok) begin
      if (idx_q == 2'd3) begin
        idx_d  = '0;
        word_d = '0;
        if (full == END_WORD) done_d = 1'b1;
        else if (we_q) ovr_d = 1'b1;
        else begin
          we_d    = 1'b1;
          wdata_d = full;
        end
      end else begin
        idx_d = idx_q + 1'b1;
        word_d[8*idx_q +: 8] = shift_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rdy_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rdy_q   <= en_i & ~done_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign rdy_o        = rdy_q;
  assign done_o       = done_q;
  assign core_rst_l_o = done_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed UART frames against hand-computed memory writes and flags.
module tb_uart_prog_loader;
  localparam int CPB = 16;
  localparam int AW  = 3;
  logic          clk, rst_l, en_i, rx_i, mem_ready_i;
  logic          mem_we_o, rdy_o, done_o, core_rst_l_o, frame_err_o, overrun_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  int checks = 0, errors = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  typedef struct {logic [31:0] word; logic [AW-1:0] addr;} vec_t;
  vec_t tbl[9];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_l(rst_l), .en_i(en_i), .rx_i(rx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .rdy_o(rdy_o), .done_o(done_o),
    .core_rst_l_o(core_rst_l_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted write is logged; checks consume the log.
  always @(negedge clk)
    if (rst_l && mem_we_o && mem_ready_i) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_wdata_o);
    end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge clk);
    bit_out(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_out(b[i], CPB);
    if (good) bit_out(1'b1, CPB);
    else begin
      bit_out(1'b0, 3 * CPB / 4);
      bit_out(1'b1, CPB / 4);
    end
    bit_out(1'b1, 4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic check_write(input string name, input logic [AW-1:0] a, input logic [31:0] d);
    int n;
    n = wa_q.size();
    chk({name, "_count"}, n, 1);
    if (n > 0) begin
      chk({name, "_addr"}, wa_q.pop_front(), a);
      chk({name, "_data"}, wd_q.pop_front(), d);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    tbl[0] = '{32'h0000_0013, 3'd0};
    tbl[1] = '{32'h0010_0093, 3'd1};
    tbl[2] = '{32'hFFFF_FFFF, 3'd2};
    tbl[3] = '{32'h0000_0000, 3'd3};
    tbl[4] = '{32'h8000_0001, 3'd4};
    tbl[5] = '{32'h1234_5678, 3'd5};
    tbl[6] = '{32'hA5A5_5A5A, 3'd6};
    tbl[7] = '{32'h0000_0FFE, 3'd7};
    tbl[8] = '{32'h0000_1FFF, 3'd0};
    rst_l = 1'b0; en_i = 1'b1; rx_i = 1'b1; mem_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_i = ~rx_i;
    end
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_core", core_rst_l_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_rdy", rdy_o, 0);
    @(negedge clk);
    rx_i = 1'b1;
    rst_l = 1'b1;
    #1 chk("rdy_before_edge", rdy_o, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", rdy_o, 1);
    idle(3);
    chk("idle_nowrite", wa_q.size(), 0);

    for (int v = 0; v < 9; v++) begin
      send_word(tbl[v].word);
      check_write($sformatf("word%0d", v), tbl[v].addr, tbl[v].word);
    end

    send_byte(8'h77, 1'b1);
    send_byte(8'h55, 1'b0);
    chk("frame_err", frame_err_o, 1);
    chk("ferr_nowrite", wa_q.size(), 0);
    send_word(32'hDDCC_BBAA);
    check_write("after_ferr", 3'd1, 32'hDDCC_BBAA);

    @(posedge clk);
    #1 mem_ready_i = 1'b0;
    send_word(32'h1111_1111);
    chk("pend_we", mem_we_o, 1);
    chk("pend_addr", mem_addr_o, 2);
    chk("pend_data", mem_wdata_o, 32'h1111_1111);
    chk("pend_no_ovr", overrun_o, 0);
    send_word(32'h2222_2222);
    chk("overrun", overrun_o, 1);
    chk("ovr_we", mem_we_o, 1);
    chk("ovr_keep_data", mem_wdata_o, 32'h1111_1111);
    chk("ovr_keep_addr", mem_addr_o, 2);
    @(posedge clk);
    #1 mem_ready_i = 1'b1;
    idle(3);
    check_write("ovr_wr", 3'd2, 32'h1111_1111);
    chk("ovr_we_drop", mem_we_o, 0);
    chk("ovr_addr_inc", mem_addr_o, 3);

    @(negedge clk);
    rx_i = 1'b0;
    idle(CPB / 4);
    rx_i = 1'b1;
    idle(3 * CPB);
    chk("glitch_nowrite", wa_q.size(), 0);
    send_word(32'h4433_2211);
    check_write("after_glitch", 3'd3, 32'h4433_2211);

    send_byte(8'hEE, 1'b1);
    send_byte(8'hEF, 1'b1);
    en_i = 1'b0;
    idle(3);
    chk("en_low_rdy", rdy_o, 0);
    en_i = 1'b1;
    idle(3);
    chk("en_high_rdy", rdy_o, 1);
    send_word(32'h0A0B_0C0D);
    check_write("after_en_drop", 3'd4, 32'h0A0B_0C0D);

    chk("pre_done", done_o, 0);
    send_word(32'h0000_0FFF);
    idle(2);
    chk("end_nowrite", wa_q.size(), 0);
    chk("done", done_o, 1);
    chk("core_rel", core_rst_l_o, 1);
    chk("done_rdy", rdy_o, 0);
    send_word(32'h1234_5678);
    chk("post_done_nowrite", wa_q.size(), 0);
    chk("post_done_addr", mem_addr_o, 5);

    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_core", core_rst_l_o, 0);
    chk("mid_rst_ferr", frame_err_o, 0);
    chk("mid_rst_ovr", overrun_o, 0);
    @(negedge clk);
    rst_l = 1'b1;
    send_word(32'hCAFE_BABE);
    check_write("after_mid_rst", 3'd0, 32'hCAFE_BABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
